// File: rtl/irig_b_frame_decoder.sv
// irig_b_frame_decoder: IRIG-B symbol stream to BCD time and control fields.
// Locks on the P0/Pr double marker and publishes each good frame atomically.
module irig_b_frame_decoder #(
  parameter int               SYM_W     = 3,
  parameter logic [SYM_W-1:0] MARK_CODE = 3'b111,
  parameter logic [SYM_W-1:0] ONE_CODE  = 3'b011,
  parameter logic [SYM_W-1:0] ZERO_CODE = 3'b001,
  parameter int               CTRL_BITS = 36,
  parameter bit               RANGE_CHK = 1'b1
) (
  input  logic                 clk,
  input  logic                 hrd_rst_n,
  input  logic                 ce,
  input  logic                 en,
  input  logic                 sym_valid,
  input  logic [SYM_W-1:0]     sym,
  output logic [1:0]           state,
  output logic [6:0]           pos,
  output logic                 locked,
  output logic                 frame_valid,
  output logic                 issue,
  output logic [6:0]           seconds,
  output logic [6:0]           minutes,
  output logic [5:0]           hours,
  output logic [9:0]           days,
  output logic [7:0]           year,
  output logic [CTRL_BITS-1:0] ctrl,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2
  } st_t;

  st_t        st_q, st_d;
  logic [6:0] pos_d;
  logic       pm_q, pm_d;
  logic       acc, is_mark, is_one, is_zero, is_data;
  logic       mark_pos, cls_ok, digits_ok, range_ok;
  logic       commit, err, data_we;
  logic       cval;
  logic [6:0] cidx;

  logic [3:0] sec_u, min_u, hr_u, day_u, day_t, yr_u, yr_t;
  logic [2:0] sec_t, min_t;
  logic [1:0] hr_t, day_h;
  logic [CTRL_BITS-1:0] ctrl_w;

  logic [6:0] sec_w, min_w;
  logic [5:0] hr_w;
  logic [9:0] day_w;
  logic [7:0] yr_w;

  assign sec_w = {sec_t, sec_u};
  assign min_w = {min_t, min_u};
  assign hr_w  = {hr_t, hr_u};
  assign day_w = {day_h, day_t, day_u};
  assign yr_w  = {yr_t, yr_u};

  assign state   = st_q;
  assign acc     = ce && sym_valid;
  assign is_mark = (sym == MARK_CODE);
  assign is_one  = (sym == ONE_CODE);
  assign is_zero = (sym == ZERO_CODE);
  assign is_data = is_one || is_zero;

  assign mark_pos = pos inside {7'd0, 7'd9, 7'd19, 7'd29, 7'd39,
                                7'd49, 7'd59, 7'd69, 7'd79, 7'd89,
                                7'd99};
  assign cls_ok   = mark_pos ? is_mark : is_data;
  assign data_we  = en && (st_q == RECV) && acc && !mark_pos && is_data;

  assign digits_ok = (sec_u <= 4'd9) && (min_u <= 4'd9) &&
                     (hr_u <= 4'd9) && (day_u <= 4'd9) &&
                     (day_t <= 4'd9) && (yr_u <= 4'd9) &&
                     (yr_t <= 4'd9);
  assign range_ok = !RANGE_CHK ||
                    (digits_ok && (sec_w <= 7'h59) &&
                     (min_w <= 7'h59) && (hr_w <= 6'h23) &&
                     (day_w >= 10'h001) && (day_w <= 10'h366));

  // next state, position, marker history, commit and error strobes
  always_comb begin
    st_d   = st_q;
    pos_d  = pos;
    pm_d   = pm_q;
    commit = 1'b0;
    err    = 1'b0;
    if (!en) begin
      st_d  = IDLE;
      pos_d = 7'd0;
      pm_d  = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d  = HUNT;
          pos_d = 7'd0;
          pm_d  = 1'b0;
        end
        HUNT: begin
          if (acc) begin
            if (is_mark && pm_q) begin
              st_d  = RECV;
              pos_d = 7'd1;
              pm_d  = 1'b0;
            end else begin
              pm_d = is_mark;
            end
          end
        end
        RECV: begin
          if (acc) begin
            if (!cls_ok || ((pos == 7'd99) && !range_ok)) begin
              err   = 1'b1;
              st_d  = HUNT;
              pos_d = 7'd0;
              pm_d  = is_mark;
            end else if (pos == 7'd99) begin
              commit = 1'b1;
              pos_d  = 7'd0;
            end else begin
              pos_d = pos + 7'd1;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // ctrl slot index of the current position (markers skipped)
  always_comb begin
    cidx = 7'd0;
    cval = 1'b0;
    unique case (1'b1)
      (pos >= 7'd60) && (pos <= 7'd68): begin
        cidx = pos - 7'd60;
        cval = 1'b1;
      end
      (pos >= 7'd70) && (pos <= 7'd78): begin
        cidx = pos - 7'd61;
        cval = 1'b1;
      end
      (pos >= 7'd80) && (pos <= 7'd88): begin
        cidx = pos - 7'd62;
        cval = 1'b1;
      end
      (pos >= 7'd90) && (pos <= 7'd98): begin
        cidx = pos - 7'd63;
        cval = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM, position, lock, pulses and error counter
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      st_q        <= IDLE;
      pos         <= 7'd0;
      pm_q        <= 1'b0;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
      issue       <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      st_q        <= st_d;
      pos         <= pos_d;
      pm_q        <= pm_d;
      frame_valid <= commit;
      issue       <= err;
      if (!en || err) begin
        locked <= 1'b0;
      end else if (commit) begin
        locked <= 1'b1;
      end
      if (err && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // working registers: data bits shifted in LSB-first per digit
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      sec_u  <= '0;
      sec_t  <= '0;
      min_u  <= '0;
      min_t  <= '0;
      hr_u   <= '0;
      hr_t   <= '0;
      day_u  <= '0;
      day_t  <= '0;
      day_h  <= '0;
      yr_u   <= '0;
      yr_t   <= '0;
      ctrl_w <= '0;
    end else if (data_we) begin
      unique case (1'b1)
        (pos >= 7'd1) && (pos <= 7'd4):
          sec_u <= {is_one, sec_u[3:1]};
        (pos >= 7'd6) && (pos <= 7'd8):
          sec_t <= {is_one, sec_t[2:1]};
        (pos >= 7'd10) && (pos <= 7'd13):
          min_u <= {is_one, min_u[3:1]};
        (pos >= 7'd15) && (pos <= 7'd17):
          min_t <= {is_one, min_t[2:1]};
        (pos >= 7'd20) && (pos <= 7'd23):
          hr_u <= {is_one, hr_u[3:1]};
        (pos >= 7'd25) && (pos <= 7'd26):
          hr_t <= {is_one, hr_t[1]};
        (pos >= 7'd30) && (pos <= 7'd33):
          day_u <= {is_one, day_u[3:1]};
        (pos >= 7'd35) && (pos <= 7'd38):
          day_t <= {is_one, day_t[3:1]};
        (pos >= 7'd40) && (pos <= 7'd41):
          day_h <= {is_one, day_h[1]};
        (pos >= 7'd50) && (pos <= 7'd53):
          yr_u <= {is_one, yr_u[3:1]};
        (pos >= 7'd55) && (pos <= 7'd58):
          yr_t <= {is_one, yr_t[3:1]};
        default: ;
      endcase
      for (int i = 0; i < CTRL_BITS; i++) begin
        if (cval && (cidx == 7'(i))) begin
          ctrl_w[i] <= is_one;
        end
      end
    end
  end

  // published fields change only on a committed frame
  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
      days    <= '0;
      year    <= '0;
      ctrl    <= '0;
    end else if (commit) begin
      seconds <= sec_w;
      minutes <= min_w;
      hours   <= hr_w;
      days    <= day_w;
      year    <= yr_w;
      ctrl    <= ctrl_w;
    end
  end

endmodule

// File: tb/tb_irig_b_frame_decoder.sv
// tb_irig_b_frame_decoder: vector table, directed corner cases and a
// randomized frame stream against a frame-level model.
module tb_irig_b_frame_decoder;

  localparam logic [2:0] MK  = 3'b111;
  localparam logic [2:0] ONE = 3'b011;
  localparam logic [2:0] ZR  = 3'b001;

  typedef struct {
    logic [6:0]  sec;
    logic [6:0]  mn;
    logic [5:0]  hr;
    logic [9:0]  dy;
    logic [7:0]  yr;
    logic [35:0] c;
    int          cpos;
    logic [2:0]  csym;
    bit          good;
    bit          chk0;
  } vec_t;

  logic        clk = 1'b0;
  logic        hrd_rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        en = 1'b0;
  logic        sym_valid = 1'b0;
  logic [2:0]  sym = 3'b000;

  logic [1:0]  state, state0;
  logic [6:0]  pos, pos0;
  logic        locked, locked0;
  logic        frame_valid, frame_valid0;
  logic        issue, issue0;
  logic [6:0]  seconds, seconds0, minutes, minutes0;
  logic [5:0]  hours, hours0;
  logic [9:0]  days, days0;
  logic [7:0]  year, year0;
  logic [35:0] ctrl, ctrl0;
  logic [7:0]  err_cnt, err_cnt0;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int iss_cnt = 0;
  int acc_cnt = 0;
  int fv_acc[$];
  int exp_err = 0;
  logic [2:0] frm [100];
  vec_t tbl [10];
  vec_t exp_v;

  always #5 clk = ~clk;

  irig_b_frame_decoder dut (
    .clk(clk), .hrd_rst_n(hrd_rst_n), .ce(ce), .en(en),
    .sym_valid(sym_valid), .sym(sym), .state(state), .pos(pos),
    .locked(locked), .frame_valid(frame_valid), .issue(issue),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .days(days), .year(year), .ctrl(ctrl), .err_cnt(err_cnt)
  );

  irig_b_frame_decoder #(.RANGE_CHK(1'b0)) dut0 (
    .clk(clk), .hrd_rst_n(hrd_rst_n), .ce(ce), .en(en),
    .sym_valid(sym_valid), .sym(sym), .state(state0), .pos(pos0),
    .locked(locked0), .frame_valid(frame_valid0), .issue(issue0),
    .seconds(seconds0), .minutes(minutes0), .hours(hours0),
    .days(days0), .year(year0), .ctrl(ctrl0), .err_cnt(err_cnt0)
  );

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_acc.push_back(acc_cnt);
    end
    if (issue) iss_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, " seconds"}, seconds, exp_v.sec);
    chk({tag, " minutes"}, minutes, exp_v.mn);
    chk({tag, " hours"}, hours, exp_v.hr);
    chk({tag, " days"}, days, exp_v.dy);
    chk({tag, " year"}, year, exp_v.yr);
    chk({tag, " ctrl"}, ctrl, exp_v.c);
  endtask

  function automatic int exp_cnt();
    return (exp_err > 255) ? 255 : exp_err;
  endfunction

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic vec_t rnd_vec(input bit allow_bad);
    vec_t v;
    int s, m, h, d, y;
    logic [11:0] b;
    if (!allow_bad || ($urandom_range(3, 0) != 0)) begin
      s = $urandom_range(59, 0);
      m = $urandom_range(59, 0);
      h = $urandom_range(23, 0);
      d = $urandom_range(366, 1);
    end else begin
      s = $urandom_range(79, 0);
      m = $urandom_range(79, 0);
      h = $urandom_range(39, 0);
      d = $urandom_range(399, 0);
    end
    y = $urandom_range(99, 0);
    b = bcd(s); v.sec = b[6:0];
    b = bcd(m); v.mn = b[6:0];
    b = bcd(h); v.hr = b[5:0];
    b = bcd(d); v.dy = b[9:0];
    b = bcd(y); v.yr = b[7:0];
    v.c = 36'({$urandom(), $urandom()});
    v.good = (s <= 59) && (m <= 59) && (h <= 23) &&
             (d >= 1) && (d <= 366);
    v.chk0 = 1'b0;
    v.cpos = -1;
    v.csym = 3'b000;
    if (allow_bad && ($urandom_range(4, 0) == 0)) begin
      v.cpos = $urandom_range(98, 1);
      case ($urandom_range(4, 0))
        0: v.csym = 3'b000;
        1: v.csym = 3'b010;
        2: v.csym = 3'b100;
        3: v.csym = 3'b101;
        default: v.csym = 3'b110;
      endcase
      v.good = 1'b0;
    end
    return v;
  endfunction

  task automatic setb(input int p, input logic b);
    frm[p] = b ? ONE : ZR;
  endtask

  task automatic build(input vec_t v);
    int k;
    for (int p = 0; p < 100; p++)
      frm[p] = ((p == 0) || (p % 10 == 9)) ? MK : ZR;
    for (int i = 0; i < 4; i++) begin
      setb(1 + i, v.sec[i]);
      setb(10 + i, v.mn[i]);
      setb(20 + i, v.hr[i]);
      setb(30 + i, v.dy[i]);
      setb(35 + i, v.dy[4 + i]);
      setb(50 + i, v.yr[i]);
      setb(55 + i, v.yr[4 + i]);
    end
    for (int i = 0; i < 3; i++) begin
      setb(6 + i, v.sec[4 + i]);
      setb(15 + i, v.mn[4 + i]);
    end
    for (int i = 0; i < 2; i++) begin
      setb(25 + i, v.hr[4 + i]);
      setb(40 + i, v.dy[8 + i]);
    end
    k = 0;
    for (int p = 60; p < 99; p++) begin
      if (p % 10 != 9) begin
        setb(p, v.c[k]);
        k++;
      end
    end
  endtask

  task automatic put(input logic [2:0] s, input int maxgap);
    int g;
    g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    for (int i = 0; i < g; i++) begin
      sym = 3'($urandom());
      case ($urandom_range(2, 0))
        0: begin ce = 1'b0; sym_valid = 1'b1; end
        1: begin ce = 1'b1; sym_valid = 1'b0; end
        default: begin ce = 1'b0; sym_valid = 1'b0; end
      endcase
      @(posedge clk); #1;
    end
    ce = 1'b1;
    sym_valid = 1'b1;
    sym = s;
    @(posedge clk); #1;
    acc_cnt++;
    sym_valid = 1'b0;
    ce = 1'($urandom());
  endtask

  task automatic send_frame(input vec_t v, input int maxgap);
    build(v);
    for (int p = 0; p < 100; p++)
      put((p == v.cpos) ? v.csym : frm[p], maxgap);
  endtask

  task automatic restart();
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int f0, i0, n0;
    vec_t va, vb;

    tbl[0] = '{7'h58, 7'h59, 6'h23, 10'h366, 8'h24, {36{1'b1}},
               -1, 3'b000, 1'b1, 1'b0};
    tbl[1] = '{7'h00, 7'h00, 6'h00, 10'h001, 8'h00, 36'h0,
               -1, 3'b000, 1'b1, 1'b0};
    tbl[2] = '{7'h59, 7'h00, 6'h00, 10'h000, 8'h99, 36'h0,
               -1, 3'b000, 1'b0, 1'b0};
    tbl[3] = '{7'h30, 7'h30, 6'h24, 10'h100, 8'h50, 36'h123456789,
               -1, 3'b000, 1'b0, 1'b1};
    tbl[4] = '{7'h10, 7'h1A, 6'h10, 10'h100, 8'h10, 36'h0,
               -1, 3'b000, 1'b0, 1'b0};
    tbl[5] = '{7'h60, 7'h00, 6'h00, 10'h100, 8'h00, 36'h0,
               -1, 3'b000, 1'b0, 1'b0};
    tbl[6] = '{7'h00, 7'h00, 6'h00, 10'h367, 8'h00, 36'h0,
               -1, 3'b000, 1'b0, 1'b0};
    tbl[7] = '{7'h12, 7'h34, 6'h12, 10'h123, 8'h99, 36'hA5A5A5A5A,
               -1, 3'b000, 1'b1, 1'b0};
    tbl[8] = '{7'h30, 7'h45, 6'h07, 10'h200, 8'h10, 36'hFFF000FFF,
               39, ZR, 1'b0, 1'b0};
    tbl[9] = '{7'h11, 7'h22, 6'h13, 10'h044, 8'h21, 36'h0,
               12, 3'b000, 1'b0, 1'b0};

    exp_v = '{7'h0, 7'h0, 6'h0, 10'h0, 8'h0, 36'h0,
              -1, 3'b000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 hrd_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst state", state, 2'd0);
    chk("rst pos", pos, 7'd0);
    chk("rst locked", locked, 1'b0);
    chk("rst frame_valid", frame_valid, 1'b0);
    chk("rst issue", issue, 1'b0);
    chk("rst err_cnt", err_cnt, 8'd0);
    chk_fields("rst");

    for (int k = 0; k < 10; k++) begin
      restart();
      f0 = fv_cnt;
      i0 = iss_cnt;
      put(MK, 0);
      send_frame(tbl[k], 0);
      @(negedge clk); #1;
      if (tbl[k].good) exp_v = tbl[k];
      else exp_err++;
      chk($sformatf("tbl%0d fv", k), fv_cnt - f0, tbl[k].good);
      chk($sformatf("tbl%0d issue", k), iss_cnt - i0, !tbl[k].good);
      chk($sformatf("tbl%0d locked", k), locked, tbl[k].good);
      chk($sformatf("tbl%0d state", k), state,
          tbl[k].good ? 2'd2 : 2'd1);
      chk($sformatf("tbl%0d err_cnt", k), err_cnt, exp_cnt());
      chk_fields($sformatf("tbl%0d", k));
      if (tbl[k].chk0) begin
        chk($sformatf("tbl%0d nochk hours", k), hours0, tbl[k].hr);
        chk($sformatf("tbl%0d nochk locked", k), locked0, 1'b1);
      end
      @(posedge clk); #1;
      chk($sformatf("tbl%0d fv width", k), frame_valid, 1'b0);
    end

    restart();
    f0 = fv_cnt;
    i0 = iss_cnt;
    n0 = fv_acc.size();
    put(MK, 3);
    for (int f = 0; f < 3; f++) begin
      va = rnd_vec(1'b0);
      send_frame(va, 3);
      exp_v = va;
    end
    @(negedge clk); #1;
    chk("b2b fv count", fv_cnt - f0, 3);
    chk("b2b issue count", iss_cnt - i0, 0);
    if (fv_acc.size() >= n0 + 3) begin
      chk("b2b spacing 1", fv_acc[n0 + 1] - fv_acc[n0], 100);
      chk("b2b spacing 2", fv_acc[n0 + 2] - fv_acc[n0 + 1], 100);
    end
    chk_fields("b2b");

    restart();
    put(MK, 1);
    for (int f = 0; f < 30; f++) begin
      va = rnd_vec(1'b1);
      f0 = fv_cnt;
      i0 = iss_cnt;
      send_frame(va, 2);
      @(negedge clk); #1;
      if (va.good) exp_v = va;
      else exp_err++;
      chk($sformatf("rnd%0d fv", f), fv_cnt - f0, va.good);
      chk($sformatf("rnd%0d issue", f), iss_cnt - i0, !va.good);
      chk($sformatf("rnd%0d locked", f), locked, va.good);
      chk($sformatf("rnd%0d err_cnt", f), err_cnt, exp_cnt());
      chk_fields($sformatf("rnd%0d", f));
    end

    restart();
    put(MK, 0);
    va = rnd_vec(1'b0);
    send_frame(va, 0);
    exp_v = va;
    vb = rnd_vec(1'b0);
    build(vb);
    for (int p = 0; p < 50; p++) put(frm[p], 0);
    chk("en pos50 pos", pos, 7'd50);
    chk("en pos50 state", state, 2'd2);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en drop state", state, 2'd0);
    chk("en drop pos", pos, 7'd0);
    chk("en drop locked", locked, 1'b0);
    chk_fields("en drop");

    en = 1'b1;
    @(posedge clk); #1;
    f0 = fv_cnt;
    put(MK, 0);
    for (int p = 0; p < 99; p++) put(frm[p], 0);
    ce = 1'b1;
    sym_valid = 1'b1;
    sym = MK;
    en = 1'b0;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    chk("en at P0 fv", frame_valid, 1'b0);
    chk("en at P0 state", state, 2'd0);
    chk("en at P0 locked", locked, 1'b0);
    chk_fields("en at P0");
    @(negedge clk); #1;
    chk("en at P0 fv count", fv_cnt - f0, 0);

    restart();
    f0 = fv_cnt;
    put(MK, 0);
    for (int p = 0; p < 31; p++) put(frm[p], 0);
    hrd_rst_n = 1'b0;
    #2;
    exp_v = '{7'h0, 7'h0, 6'h0, 10'h0, 8'h0, 36'h0,
              -1, 3'b000, 1'b0, 1'b0};
    exp_err = 0;
    chk("mid rst state", state, 2'd0);
    chk("mid rst pos", pos, 7'd0);
    chk("mid rst locked", locked, 1'b0);
    chk("mid rst err_cnt", err_cnt, 8'd0);
    chk_fields("mid rst");
    #2;
    hrd_rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mid rst fv count", fv_cnt - f0, 0);

    restart();
    put(MK, 0);
    for (int p = 0; p < 12; p++) put(frm[p], 0);
    put(3'b000, 0);
    @(negedge clk); #1;
    exp_err++;
    chk("bad code issue", issue, 1'b1);
    chk("bad code err_cnt", err_cnt, exp_cnt());
    chk("bad code state", state, 2'd1);
    i0 = iss_cnt;
    for (int e = 0; e < 299; e++) begin
      put(MK, 0);
      put(MK, 0);
      put(3'b000, 0);
      exp_err++;
    end
    @(negedge clk); #1;
    chk("sat err_cnt", err_cnt, exp_cnt());
    chk("sat issue count", iss_cnt - i0, 299);
    chk("sat locked", locked, 1'b0);
    chk_fields("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
